// File: rtl/y86_instr_encoder.sv
// rtl/y86_instr_encoder.sv - Y86 program loader: serialises decoded instructions into byte-wide instruction memory writes
// Optional feature macro: ENC_FIELD_CHECK_EN (per-icode ifun/register legality checks, reported on err_field).
module y86_instr_encoder #(
  parameter int MEM_BYTES = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_addr,
  input  logic [63:0]      start_addr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic [63:0]      valC,
  output logic             wr_en,
  output logic [63:0]      wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic             done,
  output logic             err_icode,
  output logic             err_ovf,
  output logic             err_field,
  output logic [63:0]      next_addr,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:             instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:       instr_len = 4'd2;
      4'h7, 4'h8:                   instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:             instr_len = 4'd10;
      default:                      instr_len = 4'd0;
    endcase
  endfunction

  function automatic logic has_reg_byte(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_reg_byte = 1'b1;
      default:                                  has_reg_byte = 1'b0;
    endcase
  endfunction

  logic [1:0]       state_q, state_d;
  logic [3:0]       icode_q, icode_d;
  logic [3:0]       ifun_q, ifun_d;
  logic [3:0]       ra_q, ra_d;
  logic [3:0]       rb_q, rb_d;
  logic [63:0]      valc_q, valc_d;
  logic [3:0]       len_q, len_d;
  logic [3:0]       idx_q, idx_d;
  logic [63:0]      next_addr_q, next_addr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             err_icode_q, err_icode_d;
  logic             err_ovf_q, err_ovf_d;
  logic             field_bad;

`ifdef ENC_FIELD_CHECK_EN
  logic             err_field_q, err_field_d;

  always_comb begin
    field_bad = 1'b0;
    case (icode)
      4'h2:       field_bad = (ifun > 4'd6) || (rA == 4'hF);
      4'h3:       field_bad = (ifun != 4'd0) || (rA != 4'hF);
      4'h4, 4'h5: field_bad = (ifun != 4'd0) || (rA == 4'hF);
      4'h6:       field_bad = (ifun > 4'd3) || (rA == 4'hF);
      4'h7:       field_bad = (ifun > 4'd6);
      4'hA, 4'hB: field_bad = (ifun != 4'd0) || (rB != 4'hF);
      default:    field_bad = (ifun != 4'd0);
    endcase
  end

  assign err_field = err_field_q;
`else
  assign field_bad = 1'b0;
  assign err_field = 1'b0;
`endif

  // 65-bit sum so an instruction near the top of the 64-bit space cannot wrap past the check
  logic [3:0]  in_len;
  logic [64:0] in_end;
  logic        in_ovf;

  assign in_len = instr_len(icode);
  assign in_end = {1'b0, next_addr_q} + 65'(in_len);
  assign in_ovf = in_end > 65'(MEM_BYTES);

  logic        emitting;
  logic        last_byte;
  logic [3:0]  valc_off;
  logic [63:0] valc_shift;
  logic [7:0]  cur_byte;

  assign emitting  = (state_q == S_EMIT);
  assign last_byte = (idx_q == len_q - 4'd1);

  // valC starts after byte0, or after the register byte when the form has one
  always_comb begin
    valc_off   = has_reg_byte(icode_q) ? (idx_q - 4'd2) : (idx_q - 4'd1);
    valc_shift = valc_q >> {valc_off, 3'b000};
    if (idx_q == 4'd0) begin
      cur_byte = {icode_q, ifun_q};
    end else if ((idx_q == 4'd1) && has_reg_byte(icode_q)) begin
      cur_byte = {ra_q, rb_q};
    end else begin
      cur_byte = valc_shift[7:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    icode_d     = icode_q;
    ifun_d      = ifun_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    valc_d      = valc_q;
    len_d       = len_q;
    idx_d       = idx_q;
    next_addr_d = next_addr_q;
    count_d     = count_q;
    done_d      = done_q;
    err_icode_d = err_icode_q;
    err_ovf_d   = err_ovf_q;
`ifdef ENC_FIELD_CHECK_EN
    err_field_d = err_field_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_addr) begin
          state_d     = S_IDLE;
          next_addr_d = start_addr;
          count_d     = '0;
          done_d      = 1'b0;
          err_icode_d = 1'b0;
          err_ovf_d   = 1'b0;
`ifdef ENC_FIELD_CHECK_EN
          err_field_d = 1'b0;
`endif
        end else if ((state_q == S_IDLE) && in_valid) begin
          if (icode > 4'hB) begin
            err_icode_d = 1'b1;
          end else if (field_bad) begin
`ifdef ENC_FIELD_CHECK_EN
            err_field_d = 1'b1;
`endif
          end else if (in_ovf) begin
            err_ovf_d = 1'b1;
          end else begin
            state_d = S_EMIT;
            icode_d = icode;
            ifun_d  = ifun;
            ra_d    = rA;
            rb_d    = rB;
            valc_d  = valC;
            len_d   = in_len;
            idx_d   = 4'd0;
          end
        end
      end
      S_EMIT: begin
        if (last_byte) begin
          next_addr_d = next_addr_q + 64'(len_q);
          count_d     = count_q + CNT_W'(1);
          if (icode_q == 4'h0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      icode_q     <= '0;
      ifun_q      <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      valc_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      next_addr_q <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      err_icode_q <= 1'b0;
      err_ovf_q   <= 1'b0;
`ifdef ENC_FIELD_CHECK_EN
      err_field_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      icode_q     <= icode_d;
      ifun_q      <= ifun_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      valc_q      <= valc_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      next_addr_q <= next_addr_d;
      count_q     <= count_d;
      done_q      <= done_d;
      err_icode_q <= err_icode_d;
      err_ovf_q   <= err_ovf_d;
`ifdef ENC_FIELD_CHECK_EN
      err_field_q <= err_field_d;
`endif
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = emitting;
  assign wr_en       = emitting;
  assign wr_addr     = emitting ? (next_addr_q + 64'(idx_q)) : 64'd0;
  assign wr_data     = emitting ? cur_byte : 8'd0;
  assign done        = done_q;
  assign err_icode   = err_icode_q;
  assign err_ovf     = err_ovf_q;
  assign next_addr   = next_addr_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_y86_instr_encoder.sv
// tb/tb_y86_instr_encoder.sv - self-checking bench for y86_instr_encoder with a byte-stream reference model
module tb_y86_instr_encoder;
  localparam int MEM = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_addr = 1'b0;
  logic [63:0] start_addr = '0;
  logic        in_valid = 1'b0;
  logic [3:0]  icode = '0, ifun = '0, rA = '0, rB = '0;
  logic [63:0] valC = '0;
  logic        in_ready, wr_en, busy, done, err_icode, err_ovf, err_field;
  logic [63:0] wr_addr, next_addr;
  logic [7:0]  wr_data;
  logic [15:0] instr_count;

  y86_instr_encoder #(.MEM_BYTES(MEM), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_addr(load_addr), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err_icode(err_icode),
    .err_ovf(err_ovf), .err_field(err_field), .next_addr(next_addr),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int busy_cycles;

  logic [63:0] cap_addr[$];
  logic [7:0]  cap_data[$];
  logic [63:0] exp_addr[$];
  logic [7:0]  exp_data[$];

  logic [63:0] m_next = '0;
  logic [15:0] m_count = '0;
  logic        m_done = 1'b0, m_err_icode = 1'b0, m_err_ovf = 1'b0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
    end
  end

  // Reference: build the byte image from the instruction-format rules
  task automatic model_issue(input logic [3:0] ic, input logic [3:0] fn,
                             input logic [3:0] a, input logic [3:0] b, input logic [63:0] c);
    logic [7:0] q[$];
    exp_addr.delete();
    exp_data.delete();
    if (ic > 4'hB) begin
      m_err_icode = 1'b1;
      return;
    end
    q.push_back({ic, fn});
    if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) q.push_back({a, b});
    if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8})
      for (int i = 0; i < 8; i++) q.push_back(8'(c >> (8 * i)));
    if (({1'b0, m_next} + 65'(q.size())) > 65'(MEM)) begin
      m_err_ovf = 1'b1;
      return;
    end
    for (int i = 0; i < q.size(); i++) begin
      exp_addr.push_back(m_next + 64'(i));
      exp_data.push_back(q[i]);
    end
    m_next  = m_next + 64'(q.size());
    m_count = m_count + 16'd1;
    if (ic == 4'h0) m_done = 1'b1;
  endtask

  task automatic do_load(input logic [63:0] a);
    load_addr  = 1'b1;
    start_addr = a;
    @(negedge clk);
    load_addr = 1'b0;
    m_next = a; m_count = '0; m_done = 1'b0; m_err_icode = 1'b0; m_err_ovf = 1'b0;
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [3:0] a, input logic [3:0] b, input logic [63:0] c);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    if (w == 100) begin
      total++; bad++;
      $display("FAIL ready_timeout in_ready=%b required=1", in_ready);
    end
    cap_addr.delete();
    cap_data.delete();
    icode = ic; ifun = fn; rA = a; rB = b; valC = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    icode = 4'($urandom); ifun = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
    valC = {$urandom, $urandom};
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 20) begin @(negedge clk); busy_cycles++; end
    model_issue(ic, fn, a, b, c);
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({wr_en, busy, done, err_icode, err_ovf, err_field, wr_data, wr_addr, next_addr, instr_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got wr_en=%b busy=%b done=%b addr=%h data=%h next=%h cnt=%0d required all zero",
               wr_en, busy, done, wr_addr, wr_data, next_addr, instr_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_irmovq();
    logic [7:0] lit[10] = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    logic ok;
    do_load(64'd0);
    send(4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708);
    ok = (cap_data.size() == 10);
    for (int i = 0; i < 10 && ok; i++)
      if (cap_data[i] !== lit[i] || cap_addr[i] !== 64'(i)) ok = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL irmovq_bytes got count=%0d required 10 bytes 30 F3 08..01 at 0..9", cap_data.size()); end
    total++;
    if (busy_cycles != 10) begin bad++; $display("FAIL irmovq_cycles got=%0d required=10", busy_cycles); end
    total++;
    if (next_addr !== 64'd10 || instr_count !== 16'd1) begin
      bad++; $display("FAIL irmovq_state got next=%0d cnt=%0d required next=10 cnt=1", next_addr, instr_count);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    send(4'h6, 4'h0, 4'h0, 4'h3, 64'd0);
    ok = (cap_data.size() == 2) && (cap_data[0] === 8'h60) && (cap_data[1] === 8'h03)
         && (cap_addr[0] === 64'd10) && (cap_addr[1] === 64'd11);
    total++;
    if (!ok) begin bad++; $display("FAIL addq_bytes got count=%0d required 60 03 at 10,11", cap_data.size()); end
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL gap_idle got ready=%b busy=%b required ready=1 busy=0", in_ready, busy);
    end
    send(4'h7, 4'h0, 4'hF, 4'hF, 64'h100);
    ok = (cap_data.size() == 9);
    for (int i = 0; i < 9 && ok; i++)
      if (cap_addr[i] !== 64'(12 + i) || cap_data[i] !== (i == 0 ? 8'h70 : (i == 2 ? 8'h01 : 8'h00))) ok = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL jmp_bytes got count=%0d required 70 00 01 00.. at 12..20", cap_data.size()); end
    total++;
    if (next_addr !== 64'd21 || instr_count !== 16'd3) begin
      bad++; $display("FAIL b2b_state got next=%0d cnt=%0d required next=21 cnt=3", next_addr, instr_count);
    end
  endtask

  task automatic test_halt_done();
    logic ok;
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
    ok = (cap_data.size() == 1) && (cap_data[0] === 8'h00) && (cap_addr[0] === 64'd22);
    total++;
    if (!ok) begin bad++; $display("FAIL halt_byte got count=%0d required 00 at 22", cap_data.size()); end
    total++;
    if (done !== 1'b1 || in_ready !== 1'b0 || m_done !== 1'b1) begin
      bad++; $display("FAIL halt_done got done=%b ready=%b required done=1 ready=0", done, in_ready);
    end
    cap_addr.delete(); cap_data.delete();
    icode = 4'h1; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (cap_data.size() != 0 || next_addr !== m_next || done !== 1'b1) begin
      bad++; $display("FAIL done_ignores got writes=%0d next=%0d required writes=0 next=%0d", cap_data.size(), next_addr, m_next);
    end
    do_load(64'h40);
    total++;
    if (done !== 1'b0 || next_addr !== 64'h40 || instr_count !== 16'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL load_from_done got done=%b next=%h cnt=%0d required done=0 next=40 cnt=0", done, next_addr, instr_count);
    end
    // load_addr beats a simultaneous in_valid
    cap_addr.delete(); cap_data.delete();
    load_addr = 1'b1; start_addr = 64'h80; in_valid = 1'b1; icode = 4'h1;
    @(negedge clk);
    load_addr = 1'b0; in_valid = 1'b0;
    do_load(64'h80);
    repeat (3) @(negedge clk);
    total++;
    if (cap_data.size() != 0 || next_addr !== 64'h80 || instr_count !== 16'd0) begin
      bad++; $display("FAIL load_wins got writes=%0d next=%h required writes=0 next=80", cap_data.size(), next_addr);
    end
  endtask

  task automatic test_bad_icode();
    send(4'hC, 4'h0, 4'h1, 4'h2, 64'h55);
    total++;
    if (err_icode !== 1'b1 || cap_data.size() != 0 || busy_cycles != 0 || next_addr !== 64'h80) begin
      bad++; $display("FAIL bad_icode got err=%b writes=%0d next=%h required err=1 writes=0 next=80", err_icode, cap_data.size(), next_addr);
    end
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    total++;
    if (cap_data.size() != 1 || cap_data[0] !== 8'h10 || cap_addr[0] !== 64'h80 || err_icode !== 1'b1) begin
      bad++; $display("FAIL after_bad_icode got writes=%0d err=%b required one 10 at 80, err sticky", cap_data.size(), err_icode);
    end
  endtask

  task automatic test_overflow();
    do_load(64'd1020);
    total++;
    if (err_icode !== 1'b0) begin bad++; $display("FAIL load_clears_err got=%b required=0", err_icode); end
    send(4'h3, 4'h0, 4'hF, 4'h1, 64'h1234);
    total++;
    if (err_ovf !== 1'b1 || cap_data.size() != 0 || next_addr !== 64'd1020) begin
      bad++; $display("FAIL ovf_reject got err=%b writes=%0d next=%0d required err=1 writes=0 next=1020", err_ovf, cap_data.size(), next_addr);
    end
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    total++;
    if (cap_data.size() != 1 || cap_data[0] !== 8'h10 || cap_addr[0] !== 64'd1020) begin
      bad++; $display("FAIL ovf_then_nop got writes=%0d required one 10 at 1020", cap_data.size());
    end
    do_load(64'd1014);
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'hA5);
    total++;
    if (err_ovf !== 1'b0 || cap_data.size() != 10 || next_addr !== 64'd1024) begin
      bad++; $display("FAIL exact_end got err=%b writes=%0d next=%0d required err=0 writes=10 next=1024", err_ovf, cap_data.size(), next_addr);
    end
    do_load(64'hFFFF_FFFF_FFFF_FFFF);
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'hA5);
    total++;
    if (err_ovf !== 1'b1 || cap_data.size() != 0) begin
      bad++; $display("FAIL ovf_nowrap got err=%b writes=%0d required err=1 writes=0", err_ovf, cap_data.size());
    end
  endtask

  task automatic test_random();
    logic ok;
    logic [3:0] ic;
    do_load(64'h100);
    for (int n = 0; n < 40; n++) begin
      ic = 4'($urandom_range(1, 12));
      send(ic, 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom});
      ok = (cap_data.size() == exp_data.size()) && (busy_cycles == exp_data.size());
      for (int i = 0; i < exp_data.size() && ok; i++)
        if (cap_data[i] !== exp_data[i] || cap_addr[i] !== exp_addr[i]) ok = 1'b0;
      total++;
      if (!ok) begin
        bad++; $display("FAIL rand_stream n=%0d icode=%h got writes=%0d cycles=%0d required=%0d", n, ic, cap_data.size(), busy_cycles, exp_data.size());
      end
    end
    total++;
    if (next_addr !== m_next || instr_count !== m_count || err_icode !== m_err_icode || err_ovf !== m_err_ovf) begin
      bad++; $display("FAIL rand_state got next=%h cnt=%0d ei=%b required next=%h cnt=%0d ei=%b", next_addr, instr_count, err_icode, m_next, m_count, m_err_icode);
    end
  endtask

  task automatic test_reset_midemit();
    do_load(64'd0);
    cap_addr.delete(); cap_data.delete();
    icode = 4'h8; ifun = 4'h0; rA = 4'hF; rB = 4'hF; valC = 64'h1122334455667788; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({wr_en, busy, done, err_icode, err_ovf, err_field, wr_data, wr_addr, next_addr, instr_count} !== '0) begin
      bad++; $display("FAIL async_reset got wr_en=%b busy=%b addr=%h next=%h required all zero", wr_en, busy, wr_addr, next_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (cap_data.size() != 4 || in_ready !== 1'b1 || next_addr !== 64'd0 || instr_count !== 16'd0) begin
      bad++; $display("FAIL reset_abort got writes=%0d ready=%b next=%h required writes=4 ready=1 next=0", cap_data.size(), in_ready, next_addr);
    end
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_back_to_back();
    test_halt_done();
    test_bad_icode();
    test_overflow();
    test_random();
    test_reset_midemit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y86_instr_encoder.md
Name: y86_instr_encoder

Overview:
- Program loader for the SEQ Y86 core; the write-side counterpart of instruction fetch.
- Accepts one decoded instruction per handshake (icode, ifun, rA, rB, valC).
- Serialises it into the Y86 byte encoding and writes one byte per cycle into instruction memory at an auto-incrementing address.
- Stops after encoding halt, so the fetch stage sees a complete, terminated program image.

Parameters:
- MEM_BYTES, 1024: instruction memory size in bytes. Valid addresses are 0..MEM_BYTES-1.
- CNT_W, 16: width of the instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_addr  in  1  strobe: set write pointer to start_addr, clear done and sticky errors.
- start_addr  in  64  base byte address for load_addr.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept an instruction.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- rA  in  4  register A (0xF = none).
- rB  in  4  register B (0xF = none).
- valC  in  64  constant, displacement or destination.
- wr_en  out  1  memory byte write strobe.
- wr_addr  out  64  byte address of the current write.
- wr_data  out  8  byte to write.
- busy  out  1  emission in progress.
- done  out  1  halt encoded; sticky.
- err_icode  out  1  sticky: illegal icode (> 0xB) offered.
- err_ovf  out  1  sticky: instruction would exceed MEM_BYTES.
- next_addr  out  64  write pointer, i.e. address of the next instruction.
- instr_count  out  CNT_W  instructions fully emitted since reset/load_addr; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0): every output is 0 (wr_en, wr_addr, wr_data, busy, done, err_*, next_addr, instr_count). State goes to IDLE.
- After reset, in_ready=1.
- Any emission in progress at reset is aborted with no further writes.

Instruction lengths by icode:
- 1 byte: 0 halt, 1 nop, 9 ret.
- 2 bytes: 2 cmovXX, 6 OPq, A pushq, B popq.
- 9 bytes: 7 jXX, 8 call.
- 10 bytes: 3 irmovq, 4 rmmovq, 5 mrmovq.

Byte layout:
- byte0 = {icode, ifun}.
- Forms with a register byte: byte1 = {rA, rB}.
- valC follows little-endian: bytes 2..9 for 10-byte forms, bytes 1..8 for 9-byte forms.

States:
- IDLE: in_ready=1.
  - Handshake when in_valid && in_ready: latch the fields, compute len, go to EMIT.
  - If icode > 0xB: set err_icode, stay in IDLE, emit nothing.
  - If next_addr+len > MEM_BYTES: set err_ovf, stay in IDLE, emit nothing.
- EMIT: in_ready=0, busy=1.
  - Each cycle: wr_en=1, wr_addr=next_addr+k, wr_data=byte k, for k=0..len-1.
  - First byte appears in the cycle after the accept.
  - On the last byte: next_addr += len, instr_count += 1. Go to DONE if icode==0, else IDLE.
- DONE: in_ready=0, done=1, no writes. Only load_addr or reset leaves DONE.

load_addr:
- Honoured only in IDLE and DONE: next_addr=start_addr; done, err_icode and err_ovf cleared; instr_count=0; state goes to IDLE.
- Ignored in EMIT.
- If load_addr and in_valid are both high in IDLE, load_addr wins and the instruction is not accepted.

Other rules:
- Back-to-back accepts are separated by one IDLE cycle (throughput of len+1 cycles per instruction).
- Latched fields are stable throughout EMIT; input changes during EMIT are ignored.
- An instruction that ends exactly at MEM_BYTES is legal.
- Address arithmetic is 64-bit unsigned. The overflow compare must not wrap.

Optional Feature:
- ENC_FIELD_CHECK_EN defined: additional legality checks at handshake. A failure sets sticky err_field and the instruction is rejected like err_icode (nothing emitted).
  - OPq requires ifun<=3.
  - jXX and cmovXX require ifun<=6.
  - All other icodes require ifun=0.
  - irmovq requires rA=F; pushq and popq require rB=F.
  - rrmovq, OPq, rmmovq and mrmovq require rA!=F.
- ENC_FIELD_CHECK_EN undefined: fields are encoded verbatim, and err_field is tied to 0.

Test Plan:
- Reset, load_addr with start_addr=0, then irmovq (icode3, rA=F, rB=3, valC=0x0102030405060708) → 10 consecutive wr_en cycles at addresses 0..9 with data 30 F3 08 07 06 05 04 03 02 01; next_addr=10; instr_count=1.
- addq %rax,%rbx (icode6, ifun0, rA0, rB3) then jmp 0x100 (icode7) at next_addr=10 → addresses 10,11 get 60 03; addresses 12..20 get 70 00 01 00 00 00 00 00 00; one in_ready-low gap between the two instructions.
- halt after nop → writes 10 then 00; done=1 and in_ready=0. A further in_valid is ignored with no writes. load_addr start_addr=0x40 → done=0, next_addr=0x40.
- icode=0xC offered → err_icode=1; no wr_en; next_addr unchanged; the next legal instruction is accepted normally.
- MEM_BYTES=16, load_addr start_addr=8, irmovq → err_ovf=1, no writes. Then nop → byte 10 written at address 8.
- rst_n low at the 4th byte of a call → all outputs 0 asynchronously; no further writes; after release in_ready=1 and next_addr=0.
